// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command controller: opcodes, FSM states and
// the STATUS byte format.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    S_OP     = 3'd0,
    S_WADDR  = 3'd1,
    S_WDATA  = 3'd2,
    S_RADDR  = 3'd3,
    S_RDUMMY = 3'd4
  } state_t;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  localparam logic [3:0] STATUS_HI    = 4'hA;
  localparam logic [7:0] ERR_CLR_ADDR = 8'hFF;

  function automatic logic [7:0] status_byte(input logic [3:0] err);
    return {STATUS_HI, err};
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Byte-level link between spi_slave and the command controller.
interface spi_cmd_ctrl_if;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       ssel_n;
  logic [7:0] response;

  modport master (output cmd, output cmd_valid, output ssel_n, input response);
  modport slave  (input cmd, input cmd_valid, input ssel_n, output response);
endinterface

// File: rtl/led_blinker.sv
// LED driver: free-running blink prescaler, XOR blink mask and output register.
module led_blinker #(
  parameter int LED_W     = 4,
  parameter int BLINK_DIV = 2**23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LED_W-1:0] base,
  input  logic [LED_W-1:0] mask,
  output logic [LED_W-1:0] led
);

  localparam int PRE_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [PRE_W-1:0] pre_r;
  logic             blink_r;
  logic [LED_W-1:0] led_r;
  logic             wrap_s;

  assign wrap_s = (pre_r == PRE_W'(BLINK_DIV - 1));

  // Prescaler, blink phase and registered LED value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_r   <= '0;
      blink_r <= 1'b0;
      led_r   <= '0;
    end else begin
      pre_r   <= wrap_s ? '0 : pre_r + PRE_W'(1);
      blink_r <= wrap_s ? ~blink_r : blink_r;
      led_r   <= base ^ (mask & {LED_W{blink_r}});
    end
  end

  assign led = led_r;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Register-file command decoder behind spi_slave: WRITE/READ/STATUS frames,
// error counter, deselect abort, idle timeout and LED drive.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int         NUM_REGS    = 8,
  parameter int         LED_W       = 4,
  parameter int         TIMEOUT_CYC = 2**20,
  parameter int         BLINK_DIV   = 2**23,
  parameter logic [7:0] ID_BYTE     = 8'hA7
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_cmd_ctrl_if.slave     bus,
  output logic [LED_W-1:0]  led,
  output logic              wr_stb,
  output logic              busy
);

  localparam int         TMO_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int         NWR     = NUM_REGS - 1;
  localparam logic [7:0] ID_ADDR = 8'(NUM_REGS - 1);

  state_t           state_r, state_nx;
  logic [7:0]       regs_r [NWR];
  logic [7:0]       addr_r, addr_nx;
  logic [3:0]       err_r, err_nx;
  logic [7:0]       response_r, rsp_nx;
  logic             rd_hold_r, rd_hold_nx;
  logic             wr_stb_r, busy_r;
  logic [TMO_W-1:0] tmo_r;
  logic             ssel_q1_r, ssel_q2_r, ssel_q3_r;
  logic             abort_s, timeout_s;
  logic             wr_en_s, err_inc_s, err_clr_s, rd_load_s;
  logic [7:0]       rd_mux_s;
  logic             rd_oor_s;

  assign abort_s   = ssel_q2_r & ~ssel_q3_r;
  assign timeout_s = (state_r != S_OP) && (tmo_r == TMO_W'(TIMEOUT_CYC - 1));
  assign rd_oor_s  = (bus.cmd >= 8'(NUM_REGS));

  // Read-data mux addressed by the incoming address byte
  always_comb begin
    rd_mux_s = 8'h00;
    for (int i = 0; i < NWR; i++) begin
      rd_mux_s = rd_mux_s | ((bus.cmd == 8'(i)) ? regs_r[i] : 8'h00);
    end
    rd_mux_s = (bus.cmd == ID_ADDR) ? ID_BYTE : rd_mux_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_OP;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state and per-byte actions; a deselect edge beats a coincident byte
  always_comb begin
    state_nx   = state_r;
    addr_nx    = addr_r;
    rd_hold_nx = rd_hold_r;
    wr_en_s    = 1'b0;
    err_inc_s  = 1'b0;
    err_clr_s  = 1'b0;
    rd_load_s  = 1'b0;
    if (abort_s) begin
      state_nx   = S_OP;
      rd_hold_nx = 1'b0;
    end else if (bus.cmd_valid) begin
      rd_hold_nx = 1'b0;
      case (state_r)
        S_OP: begin
          case (bus.cmd)
            OP_WRITE:          state_nx = S_WADDR;
            OP_READ:           state_nx = S_RADDR;
            OP_NOP, OP_STATUS: state_nx = S_OP;
            default: begin
              state_nx  = S_OP;
              err_inc_s = 1'b1;
            end
          endcase
        end
        S_WADDR: begin
          addr_nx  = bus.cmd;
          state_nx = S_WDATA;
        end
        S_WDATA: begin
          if (addr_r == ERR_CLR_ADDR) begin
            err_clr_s = 1'b1;
          end else if (addr_r < 8'(NWR)) begin
            wr_en_s = 1'b1;
          end else begin
            err_inc_s = 1'b1;
          end
          state_nx = S_OP;
        end
        S_RADDR: begin
          rd_load_s  = 1'b1;
          rd_hold_nx = 1'b1;
          err_inc_s  = rd_oor_s;
          state_nx   = S_RDUMMY;
        end
        S_RDUMMY: state_nx = S_OP;
        default:  state_nx = S_OP;
      endcase
    end else if (timeout_s) begin
      state_nx   = S_OP;
      rd_hold_nx = 1'b0;
      err_inc_s  = 1'b1;
    end else begin
      state_nx = state_r;
    end

    if (err_clr_s) begin
      err_nx = 4'h0;
    end else if (err_inc_s && (err_r != 4'hF)) begin
      err_nx = err_r + 4'd1;
    end else begin
      err_nx = err_r;
    end

    if (rd_load_s) begin
      rsp_nx = rd_oor_s ? 8'h00 : rd_mux_s;
    end else if (rd_hold_nx) begin
      rsp_nx = response_r;
    end else begin
      rsp_nx = status_byte(err_nx);
    end
  end

  // Datapath: register file, error counter, response, timer and ssel synchroniser
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NWR; i++) begin
        regs_r[i] <= 8'h00;
      end
      addr_r     <= 8'h00;
      err_r      <= 4'h0;
      response_r <= status_byte(4'h0);
      rd_hold_r  <= 1'b0;
      wr_stb_r   <= 1'b0;
      busy_r     <= 1'b0;
      tmo_r      <= '0;
      ssel_q1_r  <= 1'b1;
      ssel_q2_r  <= 1'b1;
      ssel_q3_r  <= 1'b1;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_en_s && (addr_r == 8'(i))) begin
          regs_r[i] <= bus.cmd;
        end
      end
      addr_r     <= addr_nx;
      err_r      <= err_nx;
      response_r <= rsp_nx;
      rd_hold_r  <= rd_hold_nx;
      wr_stb_r   <= wr_en_s;
      busy_r     <= (state_nx != S_OP);
      tmo_r      <= ((state_r == S_OP) || bus.cmd_valid || timeout_s) ? '0 : tmo_r + TMO_W'(1);
      ssel_q1_r  <= bus.ssel_n;
      ssel_q2_r  <= ssel_q1_r;
      ssel_q3_r  <= ssel_q2_r;
    end
  end

  led_blinker #(
    .LED_W     (LED_W),
    .BLINK_DIV (BLINK_DIV)
  ) u_led_blinker (
    .clk   (clk),
    .rst_n (rst_n),
    .base  (regs_r[0][LED_W-1:0]),
    .mask  (regs_r[1][LED_W-1:0]),
    .led   (led)
  );

  assign bus.response = response_r;
  assign wr_stb       = wr_stb_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl with small timeout/blink parameters.
module tb_spi_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] led;
  logic       wr_stb;
  logic       busy;
  int         errors = 0;
  int         checks = 0;

  spi_cmd_ctrl_if bus ();

  spi_cmd_ctrl #(
    .NUM_REGS    (7),
    .LED_W       (4),
    .TIMEOUT_CYC (16),
    .BLINK_DIV   (4),
    .ID_BYTE     (8'hA7)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .led    (led),
    .wr_stb (wr_stb),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.cmd       = b;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_led_change(input string tag);
    logic [3:0] prev;
    logic       seen;
    prev = led;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (led !== prev) seen = 1'b1;
    end
    check(tag, {7'd0, seen}, 8'h01);
  endtask

  initial begin : stim
    logic [3:0] v;
    rst_n         = 1'b0;
    bus.cmd       = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.ssel_n    = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_resp", bus.response, 8'hA0);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_led", {4'd0, led}, 8'h00);
    check("rst_wrstb", {7'd0, wr_stb}, 8'h00);

    // STATUS opcode
    send(8'h03);
    check("status_resp", bus.response, 8'hA0);
    check("status_busy", {7'd0, busy}, 8'h00);

    // Write reg0 = 05, then read it back
    send(8'h01);
    check("wr_busy", {7'd0, busy}, 8'h01);
    send(8'h00);
    send(8'h05);
    check("wr_stb_hi", {7'd0, wr_stb}, 8'h01);
    tick();
    check("wr_stb_lo", {7'd0, wr_stb}, 8'h00);
    check("led_reg0", {4'd0, led}, 8'h05);
    send(8'h02);
    send(8'h00);
    check("rd_reg0", bus.response, 8'h05);
    send(8'h3C);
    check("rd_dummy_resp", bus.response, 8'hA0);
    check("rd_dummy_busy", {7'd0, busy}, 8'h00);

    // Blink mask reg1 = 0F: led alternates 5/A every 4 cycles
    send(8'h01);
    send(8'h01);
    send(8'h0F);
    wait_led_change("blink_edge1");
    wait_led_change("blink_edge2");
    v = led;
    check("blink_val", {7'd0, (v == 4'h5) || (v == 4'hA)}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("blink_hold_a", {4'd0, led}, {4'd0, v});
    end
    tick();
    check("blink_flip", {4'd0, led}, {4'd0, v ^ 4'hF});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("blink_hold_b", {4'd0, led}, {4'd0, v ^ 4'hF});
    end

    // Invalid opcodes, out-of-range write, error clear, saturation
    send(8'h7E);
    check("inv1", bus.response, 8'hA1);
    send(8'h7E);
    send(8'h7E);
    check("inv3", bus.response, 8'hA3);
    send(8'h01);
    send(8'h09);
    send(8'h11);
    check("oor_wr_resp", bus.response, 8'hA4);
    check("oor_wr_stb", {7'd0, wr_stb}, 8'h00);
    send(8'h01);
    send(8'hFF);
    send(8'h00);
    check("clr_resp", bus.response, 8'hA0);
    check("clr_stb", {7'd0, wr_stb}, 8'h00);
    for (int i = 0; i < 20; i++) send(8'h7E);
    check("sat_resp", bus.response, 8'hAF);
    send(8'h01);
    send(8'hFF);
    send(8'h00);
    check("clr2_resp", bus.response, 8'hA0);

    // Deselect aborts a partial write
    send(8'h01);
    send(8'h02);
    check("abort_pre_busy", {7'd0, busy}, 8'h01);
    bus.ssel_n = 1'b1;
    repeat (4) tick();
    check("abort_busy", {7'd0, busy}, 8'h00);
    check("abort_resp", bus.response, 8'hA0);
    bus.ssel_n = 1'b0;
    repeat (4) tick();
    send(8'h02);
    send(8'h02);
    check("abort_reg2", bus.response, 8'h00);
    send(8'h00);
    check("abort_rd_end", bus.response, 8'hA0);

    // Stall mid-frame until the timeout fires
    send(8'h01);
    send(8'h02);
    repeat (12) tick();
    check("tmo_early_busy", {7'd0, busy}, 8'h01);
    repeat (8) tick();
    check("tmo_busy", {7'd0, busy}, 8'h00);
    check("tmo_resp", bus.response, 8'hA1);
    send(8'h02);
    send(8'h02);
    check("tmo_reg2", bus.response, 8'h00);
    send(8'h00);
    check("tmo_rd_end", bus.response, 8'hA1);

    // Deselect edge coincident with a WRITE opcode: byte dropped
    bus.ssel_n = 1'b1;
    tick();
    tick();
    send(8'h01);
    check("coinc_busy", {7'd0, busy}, 8'h00);
    check("coinc_resp", bus.response, 8'hA1);
    bus.ssel_n = 1'b0;
    repeat (4) tick();

    // Reset in S_WDATA
    send(8'h01);
    send(8'h03);
    check("pre_rst_busy", {7'd0, busy}, 8'h01);
    rst_n = 1'b0;
    tick();
    check("mid_rst_resp", bus.response, 8'hA0);
    check("mid_rst_busy", {7'd0, busy}, 8'h00);
    check("mid_rst_led", {4'd0, led}, 8'h00);
    check("mid_rst_wrstb", {7'd0, wr_stb}, 8'h00);
    rst_n = 1'b1;
    tick();
    send(8'h02);
    send(8'h03);
    check("post_rst_reg3", bus.response, 8'h00);
    send(8'h00);

    // ID register is read-only; out-of-range read returns 00
    send(8'h01);
    send(8'h06);
    send(8'h33);
    check("id_wr_stb", {7'd0, wr_stb}, 8'h00);
    check("id_wr_resp", bus.response, 8'hA1);
    send(8'h02);
    send(8'h06);
    check("id_rd", bus.response, 8'hA7);
    send(8'h00);
    check("id_rd_end", bus.response, 8'hA1);
    send(8'h02);
    send(8'h09);
    check("oor_rd", bus.response, 8'h00);
    send(8'h00);
    check("oor_rd_end", bus.response, 8'hA2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
